// File: rtl/spad_sram_arbiter.sv
// Scratchpad SRAM-port arbiter: exclusive multi-beat reservations, one SRAM port, tagged read routing.
// Optional macro SPAD_ARB_STARVE_GUARD_EN promotes requesters that have waited STARVE_LIMIT cycles.
module spad_sram_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 128,
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        reserved,
  output logic                      sram_en,
  output logic                      sram_we,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  input  logic [DATA_W-1:0]         sram_rdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                          r_state, w_nextState;
  logic [NUM_REQ-1:0]              r_reserved;
  logic [IDX_W-1:0]                r_owner;
  logic [IDX_W-1:0]                w_winner;
  logic                            w_anyValid;
  logic                            w_grant;
  logic                            w_accept;
  logic                            w_release;
  logic                            r_sramEn;
  logic                            r_sramWe;
  logic [ADDR_W-1:0]               r_sramAddr;
  logic [DATA_W-1:0]               r_sramWdata;
  logic [IDX_W-1:0]                r_sramOwner;
  logic [RD_LAT:0]                 r_tagValid;
  logic [RD_LAT:0][IDX_W-1:0]      r_tagOwner;
  logic [NUM_REQ-1:0]              r_respValid;
  logic [DATA_W-1:0]               r_respRdata;

`ifdef SPAD_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [NUM_REQ-1:0][CNT_W-1:0]   r_waitCnt;
`endif

  assign w_accept  = (r_state == LOCKED) && req_valid[r_owner] && r_reserved[r_owner];
  assign w_release = w_accept && req_last[r_owner];

  // Descending scans so the lowest index wins; a starved requester overrides normal priority.
  always_comb begin
    w_winner   = '0;
    w_anyValid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_winner   = IDX_W'(i);
        w_anyValid = 1'b1;
      end
    end
`ifdef SPAD_ARB_STARVE_GUARD_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (r_waitCnt[i] == CNT_W'(STARVE_LIMIT))) begin
        w_winner = IDX_W'(i);
      end
    end
`endif
  end

  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyValid) begin
          w_nextState = LOCKED;
          w_grant     = 1'b1;
        end
      end
      LOCKED: begin
        if (w_release) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_reserved <= '0;
      r_owner    <= '0;
    end else if (w_grant) begin
      r_reserved <= NUM_REQ'(1) << w_winner;
      r_owner    <= w_winner;
    end else if (w_release) begin
      r_reserved <= '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sramEn    <= 1'b0;
      r_sramWe    <= 1'b0;
      r_sramAddr  <= '0;
      r_sramWdata <= '0;
      r_sramOwner <= '0;
    end else if (w_accept) begin
      r_sramEn    <= 1'b1;
      r_sramWe    <= req_write[r_owner];
      r_sramAddr  <= req_addr[r_owner*ADDR_W +: ADDR_W];
      r_sramWdata <= req_wdata[r_owner*DATA_W +: DATA_W];
      r_sramOwner <= r_owner;
    end else begin
      r_sramEn    <= 1'b0;
      r_sramWe    <= 1'b0;
    end
  end

  // The tag enters when the SRAM samples the strobe and leaves together with the read data.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_tagValid  <= '0;
      r_tagOwner  <= '0;
      r_respValid <= '0;
      r_respRdata <= '0;
    end else begin
      r_tagValid <= {r_tagValid[RD_LAT-1:0], (r_sramEn && !r_sramWe)};
      r_tagOwner <= {r_tagOwner[RD_LAT-1:0], r_sramOwner};
      if (r_tagValid[RD_LAT]) begin
        r_respValid <= NUM_REQ'(1) << r_tagOwner[RD_LAT];
        r_respRdata <= sram_rdata;
      end else begin
        r_respValid <= '0;
      end
    end
  end

`ifdef SPAD_ARB_STARVE_GUARD_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_waitCnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant && (w_winner == IDX_W'(i))) begin
          r_waitCnt[i] <= '0;
        end else if (req_valid[i] && !r_reserved[i] && (r_waitCnt[i] != CNT_W'(STARVE_LIMIT))) begin
          r_waitCnt[i] <= r_waitCnt[i] + 1'b1;
        end
      end
    end
  end
`endif

  assign reserved   = r_reserved;
  assign sram_en    = r_sramEn;
  assign sram_we    = r_sramWe;
  assign sram_addr  = r_sramAddr;
  assign sram_wdata = r_sramWdata;
  assign resp_valid = r_respValid;
  assign resp_rdata = r_respRdata;

endmodule
